data_mem_ctrl: RTL and testbench

//  Parametrised synchronous data memory for the MEM stage: byte/half/word load-store,

---
 rtl/data_mem_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: synchronous 32-bit data memory for the MEM stage.
// Byte/half/word loads and stores, sign/zero extension, alignment faults,
// valid/ready request port, WAIT_CYCLES stall states and a post-reset
// clear sweep of every word.
// Optional build macro DM_TRACE_EN: prints each committed store.
module data_mem_ctrl #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {CLEAR, IDLE, WAIT, ACCESS, RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   clr_idx_q, clr_idx_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic                   we_q, we_d;
  logic [1:0]             width_q, width_d;
  logic                   sext_q, sext_d;
  logic [ADDR_BITS+1:0]   addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            resp_rdata_q, resp_rdata_d;
  logic                   resp_fault_q, resp_fault_d;

  logic [ADDR_BITS-1:0]   idx;
  logic [1:0]             lane;
  logic [31:0]            rd_word;
  logic                   fault;
  logic [3:0]             st_be;
  logic [31:0]            st_data;
  logic [31:0]            ld_shift;
  logic [31:0]            ld_ext;

  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_widx;
  logic [3:0]             mem_be;
  logic [31:0]            mem_wword;

  logic                   unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

  assign idx     = addr_q[ADDR_BITS+1:2];
  assign lane    = addr_q[1:0];
  assign rd_word = mem[idx];

  // Alignment / reserved-width fault detection on the latched request
  always_comb begin
    fault = 1'b0;
    case (width_q)
      2'd0:    fault = (lane != 2'b00);
      2'd1:    fault = lane[0];
      2'd2:    fault = 1'b0;
      default: fault = 1'b1;
    endcase
  end

  // Store lane enables and replicated store data
  always_comb begin
    st_be   = 4'b0000;
    st_data = wdata_q;
    case (width_q)
      2'd0: st_be = 4'b1111;
      2'd1: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      2'd2: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{wdata_q[7:0]}};
      end
      default: st_be = 4'b0000;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    ld_shift = rd_word >> {lane, 3'b000};
    case (width_q)
      2'd1:    ld_ext = {{16{sext_q & ld_shift[15]}}, ld_shift[15:0]};
      2'd2:    ld_ext = {{24{sext_q & ld_shift[7]}}, ld_shift[7:0]};
      default: ld_ext = rd_word;
    endcase
  end

  // Next-state, request latching, memory write port and outputs
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    wait_cnt_d   = wait_cnt_q;
    we_d         = we_q;
    width_d      = width_q;
    sext_d       = sext_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_we       = 1'b0;
    mem_widx     = clr_idx_q;
    mem_be       = '0;
    mem_wword    = '0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == '1) state_d = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          width_d = req_width;
          sext_d  = req_sext;
          addr_d  = req_addr[ADDR_BITS+1:0];
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            wait_cnt_d = WAIT_INIT;
            state_d    = WAIT;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) state_d = ACCESS;
        else                  wait_cnt_d = wait_cnt_q - 8'd1;
      end
      ACCESS: begin
        resp_fault_d = fault;
        resp_rdata_d = (we_q || fault) ? '0 : ld_ext;
        if (we_q && !fault) begin
          mem_we    = 1'b1;
          mem_widx  = idx;
          mem_be    = st_be;
          mem_wword = st_data;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Control and response registers; request fields are not reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      resp_rdata_q <= '0;
      resp_fault_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
    wait_cnt_q <= wait_cnt_d;
    we_q       <= we_d;
    width_q    <= width_d;
    sext_q     <= sext_d;
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
  end

  // Byte-enabled memory write; a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_widx][8*b +: 8] <= mem_wword[8*b +: 8];
      end
    end
  end

  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

`ifdef DM_TRACE_EN
  logic [31:0] pc_q;
  logic [31:0] merged;

  // Post-write word contents for the store trace
  always_comb begin
    merged = rd_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (st_be[b]) merged[8*b +: 8] = st_data[8*b +: 8];
    end
  end

  // PC capture alongside the other request fields
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) pc_q <= req_pc;
  end

  // Trace each committed store
  always_ff @(posedge clk) begin
    if (!reset && state_q == ACCESS && we_q && !fault)
      $display("@%h: *%h <= %h", pc_q, 32'({idx, 2'b00}), merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  localparam int unsigned AB    = 6;
  localparam int unsigned WC    = 3;
  localparam int unsigned DEPTH = 1 << AB;
  localparam int unsigned NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_width = 2'd0;
  logic        req_sext = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [NBYTE];

  typedef struct {
    logic        we;
    logic [1:0]  width;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  data_mem_ctrl #(.ADDR_BITS(AB), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_width(req_width), .req_sext(req_sext),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] w, input logic sx,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic ef);
    vec_t v;
    v.we = we; v.width = w; v.sext = sx; v.addr = a; v.wdata = d;
    v.exp_rdata = er; v.exp_fault = ef;
    return v;
  endfunction

  // Byte-addressed little-endian reference memory
  task automatic model(input logic we, input logic [1:0] w, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic flt);
    int unsigned base, nb;
    logic [31:0] v;
    base = a % NBYTE;
    nb   = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
    flt  = (w == 2'd3) || (base % nb != 0);
    rd   = '0;
    if (!flt) begin
      if (we) begin
        for (int i = 0; i < int'(nb); i++) ref_mem[base + i] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < int'(nb); i++) v = v | (32'(ref_mem[base + i]) << (8*i));
        if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        rd = v;
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(NBYTE); i++) ref_mem[i] = 8'h00;
  endtask

  // Called at the negedge right after the reset edge
  task automatic check_after_reset(input string tag);
    int n, pulses;
    check32({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check32({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check32({tag, "_resp_fault"}, {31'b0, resp_fault}, 32'd0);
    n = 0; pulses = 0;
    while (!req_ready && n < int'(DEPTH) + 20) begin
      if (resp_valid) pulses++;
      @(negedge clk);
      n++;
    end
    check32({tag, "_clear_cycles"}, 32'(n), 32'(DEPTH));
    check32({tag, "_clear_pulses"}, 32'(pulses), 32'd0);
    clear_model();
  endtask

  // One request: returns response and edges from accept to resp_valid
  task automatic do_req(input logic we, input logic [1:0] w, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic flt,
                        output int lat, output int ready_hi);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = we; req_width = w; req_sext = sx;
    req_addr = a; req_wdata = d; req_pc = req_pc + 32'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom();
    lat = 0; ready_hi = 0;
    while (!resp_valid && lat < 50) begin
      if (req_ready) ready_hi++;
      @(negedge clk);
      lat++;
    end
    if (req_ready) ready_hi++;
    rd  = resp_rdata;
    flt = resp_fault;
    if (!resp_valid) lat = -1;
  endtask

  task automatic run_check(input string name, input logic we, input logic [1:0] w,
                           input logic sx, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] er, input logic ef);
    logic [31:0] rd;
    logic flt;
    int lat, rh;
    do_req(we, w, sx, a, d, rd, flt, lat, rh);
    check32({name, "_rdata"}, rd, er);
    check32({name, "_fault"}, {31'b0, flt}, {31'b0, ef});
    check32({name, "_latency"}, 32'(lat), 32'(WC + 1));
    check32({name, "_ready_busy"}, 32'(rh), 32'd0);
  endtask

  initial begin
    logic [31:0] mr, a, d;
    logic mf, we, sx;
    logic [1:0] w;
    logic [15:0] vbits, rbits;
    logic [31:0] held;

    // Directed vectors: {we, width, sext, addr, wdata, expected rdata, expected fault}
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0000_00FC, 32'h0,         32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_0011, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_0033, 1'b0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_1122, 1'b0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0000_0022, 32'h0000_00AB, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0,         32'hFFAB_FFFF, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h0000_0020, 32'h0000_8001, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b1, 32'h0000_0020, 32'h0,         32'hFFFF_8001, 1'b0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0,         32'h0000_FFAB, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b1, 32'h0000_0021, 32'h0,         32'hFFFF_FF80, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0000_0006, 32'h0,         32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h0000_0005, 32'h0000_1234, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b1, 2'd3, 1'b0, 32'h0000_0010, 32'h0000_DEAD, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h0000_0012, 32'h5555_5555, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0,         32'h1122_3344, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h0000_0113, 32'h55AA_77CC, 32'h0000_0000, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'hABCD_0110, 32'h0,         32'hCC22_3344, 1'b0));

    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_after_reset("reset0");

    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].width, vecs[i].sext, vecs[i].addr, vecs[i].wdata, mr, mf);
      run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].width, vecs[i].sext,
                vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_fault);
    end

    // Wait-state timing: sample resp_valid/req_ready after each edge from accept
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = 2'd0; req_sext = 1'b0;
    req_addr = 32'h0000_0010;
    @(posedge clk);
    vbits = '0; rbits = '0;
    for (int k = 0; k <= int'(WC) + 2; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      vbits[k] = resp_valid;
      rbits[k] = req_ready;
      if (k == int'(WC) + 1) held = resp_rdata;
    end
    check32("wait_resp_valid_edges", {16'b0, vbits}, 32'(1) << (WC + 1));
    check32("wait_req_ready_edges", {16'b0, rbits}, 32'(1) << (WC + 2));
    check32("wait_rdata", held, 32'hCC22_3344);
    check32("rdata_hold", resp_rdata, 32'hCC22_3344);

    // Reset while a store is in ACCESS: no response, store lost, memory cleared
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = 2'd0;
    req_addr = 32'h0000_0040; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (WC) @(negedge clk);
    check32("pre_reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_after_reset("reset1");
    run_check("post_clear_0x40", 1'b0, 2'd0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b0);
    run_check("post_clear_0x10", 1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      w  = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      a  = ($urandom() << 8) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2'd0) a[1:0] = 2'b00;
        if (w == 2'd1) a[0] = 1'b0;
        if (w == 2'd3) w = 2'd2;
      end
      d = $urandom();
      model(we, w, sx, a, d, mr, mf);
      run_check($sformatf("rand%0d", i), we, w, sx, a, d, mr, mf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
